// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory word port between I-cache refills and D-cache refill/write-back bursts.
// Optional ARB_RR_EN: round-robin tie-break instead of fixed D-side priority.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_LOG = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic                ic_gnt,
  output logic                ic_rvalid,
  output logic [31:0]         ic_rdata,
  output logic [LINE_LOG-1:0] ic_beat,
  output logic                ic_done,
  input  logic                dc_req,
  input  logic                dc_we,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [31:0]         dc_wdata,
  output logic [LINE_LOG-1:0] dc_wbeat,
  output logic                dc_wnext,
  output logic                dc_gnt,
  output logic                dc_rvalid,
  output logic [31:0]         dc_rdata,
  output logic [LINE_LOG-1:0] dc_beat,
  output logic                dc_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata
);

  localparam int BASE_W = ADDR_W - LINE_LOG - 2;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t              state_q, state_d;
  logic [LINE_LOG-1:0] beat_q, beat_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                dir_q, dir_d;
  logic                pick_d;
  logic                last_beat;
  logic                wr_mode;
  logic                ic_hs, dc_rd_hs;

  logic                ic_rvalid_q, ic_done_q, dc_rvalid_q, dc_done_q;
  logic [31:0]         ic_rdata_q, dc_rdata_q;
  logic [LINE_LOG-1:0] ic_beat_q, dc_beat_q;

  logic unused_offs;
  assign unused_offs = ^{ic_addr[LINE_LOG+1:0], dc_addr[LINE_LOG+1:0]};

`ifdef ARB_RR_EN
  // last_d_q: 1 = D side owned the port most recently, 0 = I side
  logic last_d_q, last_d_d;

  always_comb begin
    pick_d = dc_req;
    if (dc_req && ic_req) pick_d = ~last_d_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`else
  always_comb pick_d = dc_req;
`endif

  assign last_beat = &beat_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    dir_d   = dir_q;
`ifdef ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (dc_req || ic_req) begin
          beat_d = '0;
          if (pick_d) begin
            state_d = GNT_D;
            base_d  = dc_addr[ADDR_W-1:LINE_LOG+2];
            dir_d   = dc_we;
`ifdef ARB_RR_EN
            last_d_d = 1'b1;
`endif
          end else begin
            state_d = GNT_I;
            base_d  = ic_addr[ADDR_W-1:LINE_LOG+2];
            dir_d   = 1'b0;
`ifdef ARB_RR_EN
            last_d_d = 1'b0;
`endif
          end
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      dir_q   <= dir_d;
    end
  end

  assign ic_gnt    = (state_q == GNT_I);
  assign dc_gnt    = (state_q == GNT_D);
  assign wr_mode   = dc_gnt & dir_q;
  assign mem_req   = ic_gnt | dc_gnt;
  assign mem_we    = wr_mode;
  assign mem_addr  = mem_req ? {base_q, beat_q, 2'b00} : '0;
  assign mem_wdata = wr_mode ? dc_wdata : '0;
  assign dc_wbeat  = wr_mode ? beat_q : '0;
  assign dc_wnext  = wr_mode & mem_ready;

  assign ic_hs    = ic_gnt & mem_ready;
  assign dc_rd_hs = dc_gnt & ~dir_q & mem_ready;

  // Read words and done pulses are registered; write done lands on the same cycle offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_rvalid_q <= 1'b0;
      ic_done_q   <= 1'b0;
      ic_rdata_q  <= '0;
      ic_beat_q   <= '0;
      dc_rvalid_q <= 1'b0;
      dc_done_q   <= 1'b0;
      dc_rdata_q  <= '0;
      dc_beat_q   <= '0;
    end else begin
      ic_rvalid_q <= ic_hs;
      ic_done_q   <= ic_hs & last_beat;
      if (ic_hs) begin
        ic_rdata_q <= mem_rdata;
        ic_beat_q  <= beat_q;
      end
      dc_rvalid_q <= dc_rd_hs;
      dc_done_q   <= dc_gnt & mem_ready & last_beat;
      if (dc_rd_hs) begin
        dc_rdata_q <= mem_rdata;
        dc_beat_q  <= beat_q;
      end
    end
  end

  assign ic_rvalid = ic_rvalid_q;
  assign ic_done   = ic_done_q;
  assign ic_rdata  = ic_rdata_q;
  assign ic_beat   = ic_beat_q;
  assign dc_rvalid = dc_rvalid_q;
  assign dc_done   = dc_done_q;
  assign dc_rdata  = dc_rdata_q;
  assign dc_beat   = dc_beat_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default fixed-priority build).
module tb_mem_port_arbiter;
  localparam logic [31:0] MAGIC = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_we, mem_ready;
  logic [31:0] ic_addr, dc_addr;
  wire  [31:0] dc_wdata, mem_rdata;
  logic        ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, dc_wnext;
  logic        mem_req, mem_we;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic [2:0]  ic_beat, dc_beat, dc_wbeat;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // D-cache write source and memory model
  assign dc_wdata  = 32'hA0 + {29'b0, dc_wbeat};
  assign mem_rdata = mem_addr ^ MAGIC;

  mem_port_arbiter #(.ADDR_W(32), .LINE_LOG(3)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_beat(ic_beat), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wbeat(dc_wbeat), .dc_wnext(dc_wnext), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_beat(dc_beat), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Read burst starting at the first granted cycle; stall bit set = mem_ready low that cycle
  task automatic rd_burst(input bit d, input logic [31:0] line, input logic [15:0] stall,
                          input int drop_k);
    int b;
    int cyc;
    b = 0;
    cyc = 0;
    while (b < 8 && cyc < 40) begin
      mem_ready = (cyc < 16) ? ~stall[cyc] : 1'b1;
      if (b == drop_k) begin
        if (d) dc_req = 1'b0;
        else   ic_req = 1'b0;
      end
      #1;
      chk("gnt",     d ? dc_gnt : ic_gnt, 1);
      chk("oth_gnt", d ? ic_gnt : dc_gnt, 0);
      chk("addr",    mem_addr, line + 4 * b);
      chk("we",      mem_we, 0);
      @(posedge clk); #1;
      if (mem_ready) begin
        chk("rvalid", d ? dc_rvalid : ic_rvalid, 1);
        chk("beat",   d ? dc_beat : ic_beat, b);
        chk("rdata",  d ? dc_rdata : ic_rdata, (line + 4 * b) ^ MAGIC);
        chk("done",   d ? dc_done : ic_done, (b == 7));
        b++;
      end else begin
        chk("rv_stall",   d ? dc_rvalid : ic_rvalid, 0);
        chk("done_stall", d ? dc_done : ic_done, 0);
      end
      chk("oth_rv", d ? ic_rvalid : dc_rvalid, 0);
      cyc++;
    end
    chk("beats", b, 8);
    chk("gnt_end", d ? dc_gnt : ic_gnt, 0);
    if (d) dc_req = 1'b0;
    else   ic_req = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic wr_burst(input logic [31:0] line);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        dc_we   = 1'b0;
        dc_addr = 32'h0000_0F00;
      end
      #1;
      chk("w_gnt",   dc_gnt, 1);
      chk("w_we",    mem_we, 1);
      chk("w_addr",  mem_addr, line + 4 * k);
      chk("w_data",  mem_wdata, 32'hA0 + k);
      chk("w_next",  dc_wnext, 1);
      chk("w_wbeat", dc_wbeat, k);
      @(posedge clk); #1;
      chk("w_rv",    dc_rvalid, 0);
      chk("w_done",  dc_done, (k == 7));
    end
    chk("w_gnt_end", dc_gnt, 0);
    chk("w_we_end",  mem_we, 0);
    chk("w_wd_end",  mem_wdata, 0);
    dc_req = 1'b0;
    @(posedge clk); #1;
    chk("w_done_once", dc_done, 0);
    chk("w_idle",      mem_req, 0);
  endtask

  initial begin
    rst = 1'b0;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b1;
    ic_addr = '0; dc_addr = '0;
    #1;
    chk("rst_ignt",  ic_gnt, 0);
    chk("rst_dgnt",  dc_gnt, 0);
    chk("rst_mreq",  mem_req, 0);
    chk("rst_mwe",   mem_we, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_irv",   ic_rvalid, 0);
    chk("rst_idone", ic_done, 0);
    chk("rst_ddone", dc_done, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_mreq", mem_req, 0);

    // I refill, ready tied high
    ic_req = 1'b1; ic_addr = 32'h0000_1234;
    @(posedge clk); #1;
    rd_burst(1'b0, 32'h1220, 16'h0, 99);
    @(posedge clk); #1;
    chk("i_done_once", ic_done, 0);
    chk("i_rv_after",  ic_rvalid, 0);

    // D write-back; we/addr changed mid-burst must be ignored
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0040;
    @(posedge clk); #1;
    wr_burst(32'h40);
    dc_we = 1'b0;

    // Tie: D first, then I granted 2 cycles after last D handshake
    ic_req = 1'b1; ic_addr = 32'h0000_2000;
    dc_req = 1'b1; dc_addr = 32'h0000_3000;
    @(posedge clk); #1;
    rd_burst(1'b1, 32'h3000, 16'h0, 99);
    chk("tie_gap_ignt", ic_gnt, 0);
    @(posedge clk); #1;
    rd_burst(1'b0, 32'h2000, 16'h0, 99);
    @(posedge clk); #1;

    // D refill with ready pattern 1,0,0,1,...
    dc_req = 1'b1; dc_addr = 32'h0000_0080;
    @(posedge clk); #1;
    rd_burst(1'b1, 32'h80, 16'b0110, 99);
    @(posedge clk); #1;
    chk("stall_done_once", dc_done, 0);

    // ic_req dropped at beat 2
    ic_req = 1'b1; ic_addr = 32'h0000_4008;
    @(posedge clk); #1;
    rd_burst(1'b0, 32'h4000, 16'h0, 2);
    @(posedge clk); #1;
    chk("drop_done_once", ic_done, 0);
    chk("drop_idle",      ic_gnt, 0);

    // Reset at beat 3 of an I refill
    ic_req = 1'b1; ic_addr = 32'h0000_1234;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_addr", mem_addr, 32'h122C);
    chk("pre_rst_rv",   ic_rvalid, 1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_mreq",  mem_req, 0);
    chk("mrst_ignt",  ic_gnt, 0);
    chk("mrst_irv",   ic_rvalid, 0);
    chk("mrst_idone", ic_done, 0);
    chk("mrst_maddr", mem_addr, 0);
    @(posedge clk); #1;
    chk("mrst_idone2", ic_done, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rd_burst(1'b0, 32'h1220, 16'h0, 99);
    @(posedge clk); #1;
    chk("final_idle", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
